// File: rtl/fir_delay_line_if.sv
// Tap-bus interface for the FIR delay line: stall/flush/strobe inputs,
// windowed tap bus, registered strobe and fill count toward the multipliers.
interface fir_delay_line_if #(
  parameter int N    = 16,
  parameter int TAPS = 4
);
  localparam int CW = $clog2(TAPS + 1);

  logic            EN;
  logic            CLR;
  logic            R_IN;
  logic [N-1:0]    D_IN;
  logic            R_OUT;
  logic [TAPS*N-1:0] D_OUT;
  logic [CW-1:0]   FILL;

  modport master (
    output EN, CLR, R_IN, D_IN,
    input  R_OUT, D_OUT, FILL
  );

  modport slave (
    input  EN, CLR, R_IN, D_IN,
    output R_OUT, D_OUT, FILL
  );
endinterface

// File: rtl/fir_delay_line.sv
// FIR sample delay line: keeps the last TAPS samples, tap 0 newest.
// Ports: CLK, RST (async high), bus.slave (EN/CLR/R_IN/D_IN in; R_OUT/D_OUT/FILL out).
module fir_delay_line #(
  parameter int N    = 16,
  parameter int TAPS = 4
) (
  input logic             CLK,
  input logic             RST,
  fir_delay_line_if.slave bus
);
  localparam int CW = $clog2(TAPS + 1);
  localparam logic [CW-1:0] FULL = CW'(TAPS);

  logic [N-1:0]  taps_q [TAPS];
  logic [N-1:0]  taps_d [TAPS];
  logic [CW-1:0] fill_q;
  logic [CW-1:0] fill_d;
  logic          rout_q;
  logic          rout_d;

  // One-hot action decode; CLR wins over stall, stall over strobe.
  logic do_clr;
  logic do_hold;
  logic do_shift;
  logic do_idle;

  assign do_clr   = bus.CLR;
  assign do_hold  = !bus.CLR && !bus.EN;
  assign do_shift = !bus.CLR && bus.EN && bus.R_IN;
  assign do_idle  = !bus.CLR && bus.EN && !bus.R_IN;

  always_comb begin
    taps_d = taps_q;
    fill_d = fill_q;
    rout_d = rout_q;
    unique case (1'b1)
      do_clr: begin
        for (int k = 0; k < TAPS; k++)
          taps_d[k] = '0;
        fill_d = '0;
        rout_d = 1'b0;
      end
      do_hold: begin
      end
      do_shift: begin
        taps_d[0] = bus.D_IN;
        for (int k = 1; k < TAPS; k++)
          taps_d[k] = taps_q[k-1];
        // Saturate at TAPS so the count never wraps.
        fill_d = (fill_q == FULL) ? fill_q
                                  : fill_q + CW'(1);
        rout_d = (fill_d == FULL);
      end
      do_idle: begin
        rout_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < TAPS; k++)
        taps_q[k] <= '0;
      fill_q <= '0;
      rout_q <= 1'b0;
    end else begin
      for (int k = 0; k < TAPS; k++)
        taps_q[k] <= taps_d[k];
      fill_q <= fill_d;
      rout_q <= rout_d;
    end
  end

  for (genvar g = 0; g < TAPS; g++) begin : g_tap
    assign bus.D_OUT[g*N +: N] = taps_q[g];
  end

  assign bus.FILL  = fill_q;
  assign bus.R_OUT = rout_q;
endmodule

// File: tb/tb_fir_delay_line.sv
// Directed bench for fir_delay_line, TAPS=4, N=16.
// Hand-computed windows; all checks through one task.
module tb_fir_delay_line;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  fir_delay_line_if #(.N(16), .TAPS(4)) bus();

  fir_delay_line #(.N(16), .TAPS(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply inputs just after an edge, then advance past the next edge.
  task automatic cyc(input logic en, input logic rin,
                     input logic clr, input logic [15:0] d);
    bus.EN   = en;
    bus.R_IN = rin;
    bus.CLR  = clr;
    bus.D_IN = d;
    @(posedge clk);
    #1;
  endtask

  task automatic obs(input string tag, input logic r,
                     input logic [2:0] f, input logic [63:0] d);
    check({tag, ".r"}, 64'(bus.R_OUT), 64'(r));
    check({tag, ".f"}, 64'(bus.FILL), 64'(f));
    check({tag, ".d"}, bus.D_OUT, d);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst      = 1'b1;
    bus.EN   = 1'b0;
    bus.R_IN = 1'b0;
    bus.CLR  = 1'b0;
    bus.D_IN = '0;
    #3;
    obs("rst", 1'b0, 3'd0, 64'h0);
    #9;
    rst = 1'b0;

    cyc(1, 1, 0, 16'd1);
    obs("fill1", 0, 1, 64'h0000_0000_0000_0001);
    cyc(1, 1, 0, 16'd2);
    obs("fill2", 0, 2, 64'h0000_0000_0001_0002);
    cyc(1, 1, 0, 16'd3);
    obs("fill3", 0, 3, 64'h0000_0001_0002_0003);
    cyc(1, 1, 0, 16'd4);
    obs("fill4", 1, 4, 64'h0001_0002_0003_0004);

    cyc(1, 1, 0, 16'd5);
    obs("ss5", 1, 4, 64'h0002_0003_0004_0005);
    cyc(1, 1, 0, 16'd6);
    obs("ss6", 1, 4, 64'h0003_0004_0005_0006);

    cyc(1, 0, 0, 16'd9);
    obs("idle1", 0, 4, 64'h0003_0004_0005_0006);
    cyc(1, 0, 0, 16'd9);
    obs("idle2", 0, 4, 64'h0003_0004_0005_0006);

    cyc(0, 1, 0, 16'd7);
    obs("stall7", 0, 4, 64'h0003_0004_0005_0006);
    cyc(1, 1, 0, 16'd7);
    obs("push7", 1, 4, 64'h0004_0005_0006_0007);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 16'd8);
      obs("stallhi", 1, 4, 64'h0004_0005_0006_0007);
    end

    cyc(1, 1, 1, 16'h7FFF);
    obs("clr", 0, 0, 64'h0);
    cyc(1, 1, 0, 16'h0011);
    obs("re1", 0, 1, 64'h0000_0000_0000_0011);
    cyc(1, 1, 0, 16'h0022);
    obs("re2", 0, 2, 64'h0000_0000_0011_0022);
    cyc(1, 1, 0, 16'h0033);
    obs("re3", 0, 3, 64'h0000_0011_0022_0033);
    cyc(1, 1, 0, 16'h0044);
    obs("re4", 1, 4, 64'h0011_0022_0033_0044);

    cyc(1, 1, 0, 16'h8000);
    obs("sgn1", 1, 4, 64'h0022_0033_0044_8000);
    cyc(1, 1, 0, 16'hFFFF);
    obs("sgn2", 1, 4, 64'h0033_0044_8000_FFFF);

    // Stall so inputs are quiet, then reset between edges.
    bus.EN   = 1'b0;
    bus.R_IN = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    obs("arst", 0, 0, 64'h0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    obs("arst_hold", 0, 0, 64'h0);
    cyc(1, 1, 0, 16'h0055);
    obs("post", 0, 1, 64'h0000_0000_0000_0055);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
